id_scan_arb: RTL
================

ID_SCAN_ARB -- requirements
Module: id_scan_arb

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of each per-channel match counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  channel has a character.
REQ-005 SHALL have ports req0_char / req1_char  input  8  ASCII character.
REQ-006 SHALL have ports req0_last / req1_last  input  1  character ends the channel's stream.
REQ-007 SHALL have ports req0_ready / req1_ready  output  1  character accepted this cycle when valid&&ready.
REQ-008 SHALL have port ctx_clr  input  2  bit i clears channel i context and counter.
REQ-009 SHALL have port out_valid  output  1  result for one accepted character.
REQ-010 SHALL have port out_ch  output  1  channel of the result.
REQ-011 SHALL have port out_match  output  1  post-character state is S2 (letters followed by digits).
REQ-012 SHALL have ports match_cnt0 / match_cnt1  output  CNT_W  per-channel match-entry count.

Function
REQ-013 SHALL classify each character: letter = 'A'-'Z' or 'a'-'z'; digit = '0'-'9'; other = anything else.
REQ-014 SHALL hold a 2-bit context per channel, with states S0=00, S1=01, S2=10.
REQ-015 SHALL transition the context: from S0, letter->S1, else S0; from S1 or S2, letter->S1, digit->S2, other->S0; code 11->S0.
REQ-016 SHALL share one classifier/next-state path and accept at most one character per cycle.
REQ-017 SHALL drive ready combinationally: only one valid channel not under clear -> that channel; both eligible -> channel not granted last; none -> both 0.
REQ-018 SHALL update the last-grant pointer only on an accepted character.
REQ-019 SHALL deassert reqi_ready while ctx_clr[i]=1.
REQ-020 SHALL, when ctx_clr[i]=1, set context i to S0 and match_cnt i to 0 next edge; ctx_clr beats any update to that channel.
REQ-021 SHALL register results with 1-cycle latency: on the edge after acceptance, out_valid=1, out_ch=granted channel, out_match=(next state==S2).
REQ-022 SHALL hold out_valid=0 in cycles after no acceptance; out_ch/out_match hold their previous values then.
REQ-023 SHALL, when the accepted character has last=1, report out_match from the computed next state, then store S0 as the channel context.
REQ-024 SHALL increment match_cnt i when the next state is S2 and the current state is not S2; at all-ones it SHALL saturate.
REQ-025 SHALL leave the context of the non-granted channel unchanged; channels SHALL never share context.

Reset
REQ-026 SHALL, while rst_n=0, immediately force: both contexts S0, match_cnt0=match_cnt1=0, out_valid=0, out_ch=0, out_match=0, pointer = channel 1 (channel 0 wins first tie).
REQ-027 SHALL, when reset occurs mid-stream, discard all in-flight context; the first accept after release SHALL start from S0.

Verification
REQ-028 SHALL pass: ch0 only, "a","b","1","2" -> out_match 0,0,1,1 one cycle after each; match_cnt0=1.
REQ-029 SHALL pass: both valid every cycle, ch0 "x9…", ch1 "7z…" -> grants alternate 0,1,0,1; ch0 results 0,1; ch1 results 0,0.
REQ-030 SHALL pass: ch1 "a","1" with last=1 on "1", then "2" -> out_match 1 then 0; context was S0 before "2".
REQ-031 SHALL pass: ctx_clr[0]=1 while req0_valid=1 in S2 -> req0_ready=0, next cycle context S0 and match_cnt0=0; ch1 unaffected.
REQ-032 SHALL pass: CNT_W=2, four "a1" tokens separated by " " -> match_cnt0 reads 1,2,3,3.
REQ-033 SHALL pass: rst_n low for 1 ns mid-stream between edges -> outputs zero immediately; next "5" gives out_match 0.

Source files
------------

// File: rtl/id_scan_arb_if.sv
// Bundle of the two character channels, per-channel clear, result port and
// counters for id_scan_arb. The master side drives characters; the slave side is the arbiter.
interface id_scan_arb_if #(
    parameter int CNT_W = 8
);
    logic             req0_valid;
    logic             req1_valid;
    logic [7:0]       req0_char;
    logic [7:0]       req1_char;
    logic             req0_last;
    logic             req1_last;
    logic             req0_ready;
    logic             req1_ready;
    logic [1:0]       ctx_clr;
    logic             out_valid;
    logic             out_ch;
    logic             out_match;
    logic [CNT_W-1:0] match_cnt0;
    logic [CNT_W-1:0] match_cnt1;
    // Per-channel context (00=S0, 01=S1, 10=S2) exposed for observation.
    logic [1:0]       dbg_ctx0;
    logic [1:0]       dbg_ctx1;

    modport master (
        output req0_valid, req1_valid, req0_char, req1_char, req0_last, req1_last, ctx_clr,
        input  req0_ready, req1_ready, out_valid, out_ch, out_match,
               match_cnt0, match_cnt1, dbg_ctx0, dbg_ctx1
    );

    modport slave (
        input  req0_valid, req1_valid, req0_char, req1_char, req0_last, req1_last, ctx_clr,
        output req0_ready, req1_ready, out_valid, out_ch, out_match,
               match_cnt0, match_cnt1, dbg_ctx0, dbg_ctx1
    );
endinterface

// File: rtl/id_scan_arb.sv
// Two-channel identifier scanner: round-robin picks one character per cycle, a shared
// classifier advances that channel's context, and entries into "letters then digits" are counted.
module id_scan_arb #(
    parameter int CNT_W = 8
) (
    input logic         clk,
    input logic         rst_n,
    id_scan_arb_if.slave bus
);
    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10
    } ctx_e;

    ctx_e             ctx0_q, ctx1_q, ctx0_d, ctx1_d;
    logic [CNT_W-1:0] cnt0_q, cnt1_q, cnt0_d, cnt1_d;
    logic             last_grant_q;
    logic             out_valid_q, out_ch_q, out_match_q;

    logic             elig0, elig1, grant0, grant1, accept;
    logic [7:0]       sel_char;
    logic             sel_last;
    logic             is_letter, is_digit;
    ctx_e             cur_ctx, nxt_ctx;
    logic             enter_s2;

    // Handshake: a character moves when reqN_valid && reqN_ready in the same cycle;
    // ready never depends on anything registered except the last-grant pointer.
    assign elig0  = bus.req0_valid && !bus.ctx_clr[0];
    assign elig1  = bus.req1_valid && !bus.ctx_clr[1];
    assign grant0 = elig0 && (!elig1 || last_grant_q);
    assign grant1 = elig1 && (!elig0 || !last_grant_q);
    assign accept = grant0 || grant1;

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    assign sel_char = grant1 ? bus.req1_char : bus.req0_char;
    assign sel_last = grant1 ? bus.req1_last : bus.req0_last;
    assign cur_ctx  = grant1 ? ctx1_q : ctx0_q;

    assign is_letter = ((sel_char >= 8'h41) && (sel_char <= 8'h5A)) ||
                       ((sel_char >= 8'h61) && (sel_char <= 8'h7A));
    assign is_digit  = (sel_char >= 8'h30) && (sel_char <= 8'h39);

    always_comb begin
        nxt_ctx = S0;
        case (cur_ctx)
            S0:      nxt_ctx = is_letter ? S1 : S0;
            S1, S2:  nxt_ctx = is_letter ? S1 : (is_digit ? S2 : S0);
            default: nxt_ctx = S0;
        endcase
    end

    assign enter_s2 = (nxt_ctx == S2) && (cur_ctx != S2);

    // Clear wins over any update; a granted channel is never under clear anyway.
    always_comb begin
        ctx0_d = ctx0_q;
        ctx1_d = ctx1_q;
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (bus.ctx_clr[0]) begin
            ctx0_d = S0;
            cnt0_d = '0;
        end else if (grant0) begin
            ctx0_d = sel_last ? S0 : nxt_ctx;
            if (enter_s2 && !(&cnt0_q)) cnt0_d = cnt0_q + 1'b1;
        end
        if (bus.ctx_clr[1]) begin
            ctx1_d = S0;
            cnt1_d = '0;
        end else if (grant1) begin
            ctx1_d = sel_last ? S0 : nxt_ctx;
            if (enter_s2 && !(&cnt1_q)) cnt1_d = cnt1_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctx0_q       <= S0;
            ctx1_q       <= S0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            last_grant_q <= 1'b1;
            out_valid_q  <= 1'b0;
            out_ch_q     <= 1'b0;
            out_match_q  <= 1'b0;
        end else begin
            ctx0_q      <= ctx0_d;
            ctx1_q      <= ctx1_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
            out_valid_q <= accept;
            if (accept) begin
                last_grant_q <= grant1;
                out_ch_q     <= grant1;
                out_match_q  <= (nxt_ctx == S2);
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_ch     = out_ch_q;
    assign bus.out_match  = out_match_q;
    assign bus.match_cnt0 = cnt0_q;
    assign bus.match_cnt1 = cnt1_q;
    assign bus.dbg_ctx0   = ctx0_q;
    assign bus.dbg_ctx1   = ctx1_q;
endmodule
